vsp_delay_cal: RTL and testbench

//  Calibration controller for the two VSMP delay-chain lanes of the AFE clock block.

---
 rtl/vsp_delay_cal.sv | 228 ++++++++++++++++++++++
 tb/tb_vsp_delay_cal.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vsp_delay_cal.sv
// VSMP delay-chain calibration controller: sweeps one lane's tap code,
// finds the longest error-free tap window and programs its centre tap.
//
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   manual_cfg    - software delay word ([7:0] lane0, [15:8] lane1, [31:16] pass-through)
//   cal_start     - pulse: calibrate lane cal_ch (ignored while busy)
//   cal_ch        - lane select, sampled with cal_start
//   cal_clear     - pulse: drop calibrated overrides / abort a running sweep
//   sample_valid  - AFE sample strobe
//   sample_err    - error flag of the strobed sample
//   vsp_config    - registered delay word to the AFE clock block
//   cal_busy      - calibration in progress
//   cal_done      - 1-cycle pulse when a calibration completes
//   cal_fail      - sticky: last calibration found no passing tap (or timed out)
//   win_start     - first tap of the best window
//   win_len       - length of the best window
//
// Optional feature: define VSP_CAL_TIMEOUT_EN to enable a MEASURE-state
// watchdog that fails the calibration when sample_valid stops.
module vsp_delay_cal #(
    parameter int TAP_MAX     = 255,
    parameter int SETTLE_CYC  = 64,
    parameter int SAMPLE_CNT  = 256,
    parameter int ERR_TH      = 0,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] manual_cfg,
    input  logic        cal_start,
    input  logic        cal_ch,
    input  logic        cal_clear,
    input  logic        sample_valid,
    input  logic        sample_err,
    output logic [31:0] vsp_config,
    output logic        cal_busy,
    output logic        cal_done,
    output logic        cal_fail,
    output logic [7:0]  win_start,
    output logic [8:0]  win_len
);

    // One counter width covers settle, sample and watchdog counts.
    localparam int CNT_MAX_A = (SETTLE_CYC > SAMPLE_CNT) ? SETTLE_CYC : SAMPLE_CNT;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYC) ? CNT_MAX_A : TIMEOUT_CYC;
    localparam int CW        = $clog2(CNT_MAX + 1);

    localparam logic [7:0]    TAP_LAST    = 8'(TAP_MAX);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] SMP_LAST    = CW'(SAMPLE_CNT - 1);
    localparam logic [15:0]   ERR_LIM     = 16'(ERR_TH);

    typedef enum logic [2:0] {
        IDLE, SET, SETTLE, MEASURE, EVAL, FINISH
    } state_t;

    state_t          state;
    logic            ch;
    logic [7:0]      tap;
    logic [CW-1:0]   settle_cnt;
    logic [CW-1:0]   smp_cnt;
    logic [15:0]     err_cnt;
    logic [8:0]      run_len;
    logic [7:0]      run_start;
    logic [8:0]      best_len;
    logic [7:0]      best_start;
    logic [1:0]      ovr;
    logic [1:0][7:0] cal_tap;

`ifdef VSP_CAL_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
    logic [CW-1:0]   wd_cnt;
`endif

    // Run/best bookkeeping for the tap being evaluated. A pass on the
    // last tap is folded into the run before it is closed.
    logic       pass;
    logic [8:0] cur_len;
    logic [7:0] cur_start;
    logic       upd;
    logic [8:0] fin_len;
    logic [7:0] fin_start;
    logic [8:0] fin_lm1;
    logic [7:0] centre;

    always_comb begin
        pass      = (err_cnt <= ERR_LIM);
        cur_len   = pass ? run_len + 9'd1 : run_len;
        cur_start = (pass && run_len == 9'd0) ? tap : run_start;
        // Strict compare keeps the earlier of equal-length windows.
        upd       = (!pass || tap == TAP_LAST) && (cur_len > best_len);
        fin_len   = upd ? cur_len : best_len;
        fin_start = upd ? cur_start : best_start;
        fin_lm1   = fin_len - 9'd1;
        centre    = fin_start + fin_lm1[8:1];
    end

    logic [7:0] lane0_n;
    logic [7:0] lane1_n;

    always_comb begin
        lane0_n = ovr[0] ? cal_tap[0] : manual_cfg[7:0];
        lane1_n = ovr[1] ? cal_tap[1] : manual_cfg[15:8];
        if (cal_busy && !ch) lane0_n = tap;
        if (cal_busy && ch)  lane1_n = tap;
    end

    always_ff @(posedge clk) begin
        if (rst) vsp_config <= '0;
        else     vsp_config <= {manual_cfg[31:16], lane1_n, lane0_n};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ch         <= 1'b0;
            tap        <= '0;
            settle_cnt <= '0;
            smp_cnt    <= '0;
            err_cnt    <= '0;
            run_len    <= '0;
            run_start  <= '0;
            best_len   <= '0;
            best_start <= '0;
            ovr        <= '0;
            cal_tap    <= '0;
            cal_busy   <= 1'b0;
            cal_done   <= 1'b0;
            cal_fail   <= 1'b0;
            win_start  <= '0;
            win_len    <= '0;
`ifdef VSP_CAL_TIMEOUT_EN
            wd_cnt     <= '0;
`endif
        end else begin
            cal_done <= 1'b0;
            if (cal_clear) begin
                // Clear beats a simultaneous start and aborts any sweep.
                ovr      <= '0;
                cal_busy <= 1'b0;
                state    <= IDLE;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (cal_start) begin
                            ch         <= cal_ch;
                            tap        <= '0;
                            run_len    <= '0;
                            run_start  <= '0;
                            best_len   <= '0;
                            best_start <= '0;
                            cal_busy   <= 1'b1;
                            state      <= SET;
                        end
                    end
                    SET: begin
                        settle_cnt <= '0;
                        smp_cnt    <= '0;
                        err_cnt    <= '0;
`ifdef VSP_CAL_TIMEOUT_EN
                        wd_cnt     <= '0;
`endif
                        state      <= SETTLE;
                    end
                    SETTLE: begin
                        if (settle_cnt == SETTLE_LAST) state <= MEASURE;
                        else settle_cnt <= settle_cnt + 1'b1;
                    end
                    MEASURE: begin
                        if (sample_valid) begin
                            smp_cnt <= smp_cnt + 1'b1;
                            if (sample_err && err_cnt != 16'hFFFF)
                                err_cnt <= err_cnt + 16'd1;
                            if (smp_cnt == SMP_LAST) state <= EVAL;
                        end
`ifdef VSP_CAL_TIMEOUT_EN
                        if (sample_valid) begin
                            wd_cnt <= '0;
                        end else if (wd_cnt == TO_LAST) begin
                            // Stalled sample stream: fail without touching ovr.
                            state     <= FINISH;
                            cal_done  <= 1'b1;
                            cal_fail  <= 1'b1;
                            win_start <= '0;
                            win_len   <= '0;
                        end else begin
                            wd_cnt <= wd_cnt + 1'b1;
                        end
`endif
                    end
                    EVAL: begin
                        run_len   <= pass ? cur_len : 9'd0;
                        run_start <= cur_start;
                        if (upd) begin
                            best_len   <= cur_len;
                            best_start <= cur_start;
                        end
                        if (tap == TAP_LAST) begin
                            // Outcome is published on entry to FINISH so it
                            // coincides with the cal_done pulse.
                            state     <= FINISH;
                            cal_done  <= 1'b1;
                            win_start <= fin_start;
                            win_len   <= fin_len;
                            if (fin_len != 9'd0) begin
                                cal_tap[ch] <= centre;
                                ovr[ch]     <= 1'b1;
                                cal_fail    <= 1'b0;
                            end else begin
                                cal_fail <= 1'b1;
                            end
                        end else begin
                            tap   <= tap + 8'd1;
                            state <= SET;
                        end
                    end
                    FINISH: begin
                        cal_busy <= 1'b0;
                        state    <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vsp_delay_cal.sv
// Randomised bench for vsp_delay_cal: an AFE model errs on taps outside a
// chosen pass mask; results are compared with a window-search model.
module tb_vsp_delay_cal;

    localparam int TAPS = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] manual_cfg = 32'h0;
    logic        cal_start = 1'b0;
    logic        cal_ch = 1'b0;
    logic        cal_clear = 1'b0;
    logic        sample_valid = 1'b0;
    logic        sample_err = 1'b0;
    logic [31:0] vsp_config;
    logic        cal_busy;
    logic        cal_done;
    logic        cal_fail;
    logic [7:0]  win_start;
    logic [8:0]  win_len;

    vsp_delay_cal #(
        .TAP_MAX(15), .SETTLE_CYC(4), .SAMPLE_CNT(4),
        .ERR_TH(0), .TIMEOUT_CYC(32)
    ) dut (
        .clk(clk), .rst(rst), .manual_cfg(manual_cfg),
        .cal_start(cal_start), .cal_ch(cal_ch), .cal_clear(cal_clear),
        .sample_valid(sample_valid), .sample_err(sample_err),
        .vsp_config(vsp_config), .cal_busy(cal_busy), .cal_done(cal_done),
        .cal_fail(cal_fail), .win_start(win_start), .win_len(win_len)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int done_total = 0;

    // AFE model state
    logic [15:0] mask = 16'h0;
    logic        sel = 1'b0;
    logic        afe_en = 1'b0;
    logic [7:0]  lane;

    // Reference model state
    logic [1:0] m_ovr = 2'b00;
    logic [7:0] m_tap [2];
    logic       m_fail = 1'b0;
    int         m_ws = 0;
    int         m_wl = 0;

    always @(negedge clk) if (cal_done) done_total++;

    // AFE: the applied delay code decides whether samples are clean.
    initial begin
        forever begin
            @(posedge clk); #1;
            lane = sel ? vsp_config[15:8] : vsp_config[7:0];
            if (afe_en && $urandom_range(0, 3) != 0) begin
                sample_valid = 1'b1;
                sample_err = (lane > 8'd15) ? 1'b1 : !mask[lane[3:0]];
            end else begin
                sample_valid = 1'b0;
                sample_err = 1'($urandom_range(0, 1));
            end
        end
    end

    // Longest run of passing taps, earliest wins ties.
    function automatic void model_cal(input logic c, input logic [15:0] m);
        int bs = 0;
        int bl = 0;
        for (int s = 0; s < TAPS; s++) begin
            if (m[s] && (s == 0 || !m[s-1])) begin
                int l = 0;
                while (s + l < TAPS && m[s+l]) l++;
                if (l > bl) begin bl = l; bs = s; end
            end
        end
        m_ws = bs;
        m_wl = bl;
        if (bl > 0) begin
            m_tap[c] = 8'(bs + (bl - 1) / 2);
            m_ovr[c] = 1'b1;
            m_fail = 1'b0;
        end else begin
            m_fail = 1'b1;
        end
    endfunction

    function automatic logic [31:0] exp_cfg();
        logic [7:0] l0 = m_ovr[0] ? m_tap[0] : manual_cfg[7:0];
        logic [7:0] l1 = m_ovr[1] ? m_tap[1] : manual_cfg[15:8];
        return {manual_cfg[31:16], l1, l0};
    endfunction

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic run_cal(input logic c, input logic [15:0] m,
                           input bit extra, input bit en,
                           output int dones, output bit to);
        int d0 = done_total;
        mask = m; sel = c; afe_en = en;
        cal_ch = c; cal_start = 1'b1;
        tick();
        cal_start = 1'b0; cal_ch = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (extra && i == 50) begin cal_start = 1'b1; cal_ch = !c; end
            if (extra && i == 51) begin cal_start = 1'b0; cal_ch = 1'b0; end
            if (!cal_busy) begin to = 1'b0; break; end
            tick();
        end
        cal_start = 1'b0;
        tick();
        dones = done_total - d0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        n_checks++;
        if ({vsp_config, cal_busy, cal_done, cal_fail, win_start, win_len} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got cfg=%h busy=%b done=%b fail=%b ws=%0d wl=%0d expected all 0",
                     vsp_config, cal_busy, cal_done, cal_fail, win_start, win_len);
        end
        rst = 1'b0;
        manual_cfg = 32'h1234_5678;
        tick();
        n_checks++;
        if (vsp_config !== 32'h1234_5678) begin
            n_fail++;
            $display("FAIL reset_manual: got %h expected 12345678", vsp_config);
        end
        n_checks++;
        if ({cal_busy, cal_done, cal_fail} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 000", {cal_busy, cal_done, cal_fail});
        end
    endtask

    task automatic test_passthrough();
        for (int i = 0; i < 4; i++) begin
            manual_cfg = $urandom;
            tick();
            n_checks++;
            if (vsp_config !== exp_cfg()) begin
                n_fail++;
                $display("FAIL passthrough: got %h expected %h", vsp_config, exp_cfg());
            end
        end
        manual_cfg = 32'h1234_5678;
        tick();
    endtask

    // Compare everything a finished calibration should leave behind.
    task automatic test_cal(input string name, input logic c,
                            input logic [15:0] m, input bit extra);
        int  dones;
        bit  to;
        run_cal(c, m, extra, 1'b1, dones, to);
        model_cal(c, m);
        n_checks++;
        if (to || dones != 1) begin
            n_fail++;
            $display("FAIL %s_done: got %0d pulses timeout=%0b expected 1 pulse", name, dones, to);
        end
        n_checks++;
        if (win_start !== 8'(m_ws) || win_len !== 9'(m_wl)) begin
            n_fail++;
            $display("FAIL %s_window: got start=%0d len=%0d expected start=%0d len=%0d",
                     name, win_start, win_len, m_ws, m_wl);
        end
        n_checks++;
        if (cal_fail !== m_fail) begin
            n_fail++;
            $display("FAIL %s_fail: got %b expected %b", name, cal_fail, m_fail);
        end
        n_checks++;
        if (vsp_config !== exp_cfg()) begin
            n_fail++;
            $display("FAIL %s_cfg: got %h expected %h", name, vsp_config, exp_cfg());
        end
    endtask

    task automatic test_window();
        test_cal("window", 1'b0, 16'h0FE0, 1'b0);
        n_checks++;
        if (vsp_config[7:0] !== 8'd8 || win_start !== 8'd5 || win_len !== 9'd7) begin
            n_fail++;
            $display("FAIL window_const: got lane0=%0d ws=%0d wl=%0d expected 8 5 7",
                     vsp_config[7:0], win_start, win_len);
        end
    endtask

    task automatic test_equal_windows();
        test_cal("equal", 1'b1, 16'h0E1C, 1'b0);
        n_checks++;
        if (vsp_config[15:0] !== 16'h0308) begin
            n_fail++;
            $display("FAIL equal_const: got %h expected 0308", vsp_config[15:0]);
        end
    endtask

    task automatic test_all_fail();
        test_cal("allfail", 1'b0, 16'h0000, 1'b0);
        n_checks++;
        if (cal_fail !== 1'b1 || win_len !== 9'd0 || vsp_config[7:0] !== 8'd8) begin
            n_fail++;
            $display("FAIL allfail_const: got fail=%b wl=%0d lane0=%0d expected 1 0 8",
                     cal_fail, win_len, vsp_config[7:0]);
        end
    endtask

    task automatic test_top_edge();
        test_cal("topedge", 1'b0, 16'hF000, 1'b0);
        n_checks++;
        if (vsp_config[7:0] !== 8'd13 || win_start !== 8'd12 || win_len !== 9'd4) begin
            n_fail++;
            $display("FAIL topedge_const: got lane0=%0d ws=%0d wl=%0d expected 13 12 4",
                     vsp_config[7:0], win_start, win_len);
        end
        cal_clear = 1'b1;
        tick();
        cal_clear = 1'b0;
        m_ovr = 2'b00;
        tick();
        n_checks++;
        if (vsp_config !== manual_cfg) begin
            n_fail++;
            $display("FAIL clear_idle: got %h expected %h", vsp_config, manual_cfg);
        end
    endtask

    task automatic test_busy_ignore();
        test_cal("busyign", 1'b1, 16'h00F0, 1'b1);
        repeat (20) tick();
        n_checks++;
        if (cal_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busyign_idle: got busy=%b expected 0", cal_busy);
        end
    endtask

    task automatic test_clear_abort();
        int  d0;
        logic f0;
        f0 = cal_fail;
        mask = 16'h00FF; sel = 1'b0; afe_en = 1'b1;
        cal_ch = 1'b0; cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        repeat (60) tick();
        d0 = done_total;
        cal_clear = 1'b1;
        tick();
        cal_clear = 1'b0;
        m_ovr = 2'b00;
        n_checks++;
        if (cal_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got %b expected 0", cal_busy);
        end
        repeat (300) tick();
        n_checks++;
        if (done_total != d0 || cal_fail !== f0) begin
            n_fail++;
            $display("FAIL abort_done: got pulses=%0d fail=%b expected 0 pulses fail=%b",
                     done_total - d0, cal_fail, f0);
        end
        n_checks++;
        if (vsp_config !== exp_cfg()) begin
            n_fail++;
            $display("FAIL abort_cfg: got %h expected %h", vsp_config, exp_cfg());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic [15:0] m;
            m = 16'($urandom);
            if (i == 3) m = 16'h0;
            if (i == 5) m = 16'hFFFF;
            manual_cfg = $urandom;
            test_cal("random", 1'($urandom_range(0, 1)), m, 1'b0);
        end
    endtask

`ifdef VSP_CAL_TIMEOUT_EN
    task automatic test_timeout();
        int dones;
        bit to;
        run_cal(1'b1, 16'hFFFF, 1'b0, 1'b0, dones, to);
        m_fail = 1'b1;
        n_checks++;
        if (to || dones != 1 || cal_fail !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout: got pulses=%0d to=%0b fail=%b expected 1 0 1",
                     dones, to, cal_fail);
        end
        n_checks++;
        if (vsp_config !== exp_cfg()) begin
            n_fail++;
            $display("FAIL timeout_cfg: got %h expected %h", vsp_config, exp_cfg());
        end
    endtask
`endif

    task automatic test_reset_abort();
        mask = 16'h0F00; sel = 1'b1; afe_en = 1'b1;
        cal_ch = 1'b1; cal_start = 1'b1;
        tick();
        cal_start = 1'b0;
        repeat (40) tick();
        rst = 1'b1;
        tick();
        m_ovr = 2'b00; m_fail = 1'b0;
        n_checks++;
        if ({vsp_config, cal_busy, cal_done, cal_fail, win_start, win_len} !== '0) begin
            n_fail++;
            $display("FAIL reset_abort: got cfg=%h busy=%b fail=%b ws=%0d wl=%0d expected all 0",
                     vsp_config, cal_busy, cal_fail, win_start, win_len);
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (vsp_config !== exp_cfg() || cal_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_resume: got %h busy=%b expected %h busy=0",
                     vsp_config, cal_busy, exp_cfg());
        end
    endtask

    initial begin
        m_tap[0] = 8'h0;
        m_tap[1] = 8'h0;
        test_reset();
        test_passthrough();
        test_window();
        test_equal_windows();
        test_all_fail();
        test_top_edge();
        test_busy_ignore();
        test_clear_abort();
        test_random();
`ifdef VSP_CAL_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
